// File: rtl/smol_pkg.sv
// Shared SmolCore types and constants for the operand-fetch slice.
// Define SMOL_OPF_BYPASS_EN to enable writeback forwarding and snooping.
package smol_pkg;

  localparam int XLEN      = 32;
  localparam int AW        = 5;
  localparam int PAYLOAD_W = 32;

  typedef logic [AW-1:0]   reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;

  localparam reg_addr_t REG_ZERO = '0;

`ifdef SMOL_OPF_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/smol_opf_fwd.sv
// Per-operand resolver: picks x0, live writeback, captured forward or RF data.
// Forwarding terms are active only when SMOL_OPF_BYPASS_EN is defined.
module smol_opf_fwd #(
  parameter int XLEN = smol_pkg::XLEN,
  parameter int AW   = smol_pkg::AW
) (
  input  logic [AW-1:0]   i_rs,
  input  logic            i_wb_we,
  input  logic [AW-1:0]   i_wb_waddr,
  input  logic [XLEN-1:0] i_wb_wdata,
  input  logic            i_fwd,
  input  logic [XLEN-1:0] i_fwd_val,
  input  logic [XLEN-1:0] i_rf_data,
  output logic [XLEN-1:0] o_val
);
  import smol_pkg::*;

  // A live write this cycle is newer than anything captured earlier.
  always_comb begin
    o_val = i_rf_data;
    if (i_rs == REG_ZERO)
      o_val = '0;
    else if (BYPASS_EN && i_wb_we && (i_wb_waddr == i_rs))
      o_val = i_wb_wdata;
    else if (BYPASS_EN && i_fwd)
      o_val = i_fwd_val;
  end

endmodule

// File: rtl/smol_operand_fetch.sv
// SmolCore operand-fetch stage: issues RF reads, covers the read latency, presents operands.
// Define SMOL_OPF_BYPASS_EN to forward and snoop writeback data.
module smol_operand_fetch #(
  parameter int XLEN      = smol_pkg::XLEN,
  parameter int AW        = smol_pkg::AW,
  parameter int PAYLOAD_W = smol_pkg::PAYLOAD_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_rs1,
  input  logic [AW-1:0]        in_rs2,
  input  logic [AW-1:0]        in_rd,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 rf_ren1,
  output logic                 rf_ren2,
  output logic [AW-1:0]        rf_raddr1,
  output logic [AW-1:0]        rf_raddr2,
  input  logic [XLEN-1:0]      rf_rdata1,
  input  logic [XLEN-1:0]      rf_rdata2,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_waddr,
  input  logic [XLEN-1:0]      wb_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_rs1_val,
  output logic [XLEN-1:0]      out_rs2_val,
  output logic [AW-1:0]        out_rd,
  output logic [PAYLOAD_W-1:0] out_payload
);
  import smol_pkg::*;

  // Slot A: read in flight.
  logic                 r_a_valid;
  logic [AW-1:0]        r_a_rs1, r_a_rs2, r_a_rd;
  logic [PAYLOAD_W-1:0] r_a_payload;
  logic                 r_a_fwd1, r_a_fwd2;
  logic [XLEN-1:0]      r_a_fwdv1, r_a_fwdv2;

  // Slot B: output register, keeps its source addresses for snooping.
  logic                 r_out_valid;
  logic [XLEN-1:0]      r_out_rs1_val, r_out_rs2_val;
  logic [AW-1:0]        r_out_rd, r_b_rs1, r_b_rs2;
  logic [PAYLOAD_W-1:0] r_out_payload;

  logic            w_accept, w_a_adv;
  logic            w_cap1, w_cap2, w_a_hit1, w_a_hit2, w_b_hit1, w_b_hit2;
  logic [XLEN-1:0] w_res1, w_res2;

  function automatic logic f_wb_hit(input logic [AW-1:0] rs);
    return BYPASS_EN && wb_we && (wb_waddr == rs) && (rs != REG_ZERO);
  endfunction

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and ready may depend on the downstream ready.
  assign w_a_adv  = r_a_valid && (!r_out_valid || out_ready);
  assign in_ready = !r_a_valid || w_a_adv;
  assign w_accept = in_valid && in_ready;

  // Both enables move together: the RF only updates port 2 when both are high.
  assign rf_ren1   = w_accept && !rst;
  assign rf_ren2   = w_accept && !rst;
  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  assign w_cap1   = f_wb_hit(in_rs1);
  assign w_cap2   = f_wb_hit(in_rs2);
  assign w_a_hit1 = f_wb_hit(r_a_rs1);
  assign w_a_hit2 = f_wb_hit(r_a_rs2);
  assign w_b_hit1 = f_wb_hit(r_b_rs1);
  assign w_b_hit2 = f_wb_hit(r_b_rs2);

  smol_opf_fwd #(.XLEN(XLEN), .AW(AW)) u_fwd1 (
    .i_rs(r_a_rs1), .i_wb_we(wb_we), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
    .i_fwd(r_a_fwd1), .i_fwd_val(r_a_fwdv1), .i_rf_data(rf_rdata1), .o_val(w_res1)
  );

  smol_opf_fwd #(.XLEN(XLEN), .AW(AW)) u_fwd2 (
    .i_rs(r_a_rs2), .i_wb_we(wb_we), .i_wb_waddr(wb_waddr), .i_wb_wdata(wb_wdata),
    .i_fwd(r_a_fwd2), .i_fwd_val(r_a_fwdv2), .i_rf_data(rf_rdata2), .o_val(w_res2)
  );

  // Capture on accept also catches the same-edge write the RF returns stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid   <= 1'b0;
      r_a_rs1     <= '0;
      r_a_rs2     <= '0;
      r_a_rd      <= '0;
      r_a_payload <= '0;
      r_a_fwd1    <= 1'b0;
      r_a_fwd2    <= 1'b0;
      r_a_fwdv1   <= '0;
      r_a_fwdv2   <= '0;
    end else if (w_accept) begin
      r_a_valid   <= 1'b1;
      r_a_rs1     <= in_rs1;
      r_a_rs2     <= in_rs2;
      r_a_rd      <= in_rd;
      r_a_payload <= in_payload;
      r_a_fwd1    <= w_cap1;
      r_a_fwd2    <= w_cap2;
      r_a_fwdv1   <= wb_wdata;
      r_a_fwdv2   <= wb_wdata;
    end else if (w_a_adv) begin
      r_a_valid <= 1'b0;
    end else if (r_a_valid) begin
      if (w_a_hit1) begin
        r_a_fwd1  <= 1'b1;
        r_a_fwdv1 <= wb_wdata;
      end
      if (w_a_hit2) begin
        r_a_fwd2  <= 1'b1;
        r_a_fwdv2 <= wb_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_rs1_val <= '0;
      r_out_rs2_val <= '0;
      r_out_rd      <= '0;
      r_out_payload <= '0;
      r_b_rs1       <= '0;
      r_b_rs2       <= '0;
    end else if (w_a_adv) begin
      r_out_valid   <= 1'b1;
      r_out_rs1_val <= w_res1;
      r_out_rs2_val <= w_res2;
      r_out_rd      <= r_a_rd;
      r_out_payload <= r_a_payload;
      r_b_rs1       <= r_a_rs1;
      r_b_rs2       <= r_a_rs2;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else if (r_out_valid) begin
      if (w_b_hit1) r_out_rs1_val <= wb_wdata;
      if (w_b_hit2) r_out_rs2_val <= wb_wdata;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_rs1_val = r_out_rs1_val;
  assign out_rs2_val = r_out_rs2_val;
  assign out_rd      = r_out_rd;
  assign out_payload = r_out_payload;

endmodule

// File: tb/tb_smol_operand_fetch.sv
// Self-checking bench for smol_operand_fetch with a behavioural register file.
// Expectations follow SMOL_OPF_BYPASS_EN when it is defined.
module tb_smol_operand_fetch;

`ifdef SMOL_OPF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int EW = 32 + 32 + 5 + 32;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_payload;
  logic        rf_ren1, rf_ren2;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1_val, out_rs2_val;
  logic [4:0]  out_rd;
  logic [31:0] out_payload;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [31:0]   tb_rf [32];
  logic [31:0]   shadow [32];
  int n_cmp = 0;
  int n_err = 0;

  smol_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_payload(in_payload),
    .rf_ren1(rf_ren1), .rf_ren2(rf_ren2), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
    .out_rd(out_rd), .out_payload(out_payload)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: one-cycle read latency, data held while enables are low.
  always @(posedge clk) begin
    if (rf_ren1 && rf_ren2) begin
      rf_rdata1 <= (rf_raddr1 == 5'd0) ? 32'd0 : tb_rf[rf_raddr1];
      rf_rdata2 <= (rf_raddr2 == 5'd0) ? 32'd0 : tb_rf[rf_raddr2];
    end
    if (wb_we && wb_waddr != 5'd0) tb_rf[wb_waddr] <= wb_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_shadow(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : shadow[a];
  endfunction

  task automatic push_exp(input logic [31:0] e1, input logic [31:0] e2,
                          input logic [4:0] rd, input logic [31:0] pl);
    exp_q.push_back({e1, e2, rd, pl});
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_waddr = a; wb_wdata = d;
    tick();
    wb_we = 1'b0;
    if (a != 5'd0) shadow[a] = d;
  endtask

  // Offer one instruction until accepted; expectation is queued on the handshake.
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] pl, input logic [31:0] e1, input logic [31:0] e2);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_payload = pl;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(e1, e2, rd, pl);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) check_val("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) tick();
    check_val("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard and port-coupling monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("rs1_val", out_rs1_val, mon_e[100:69]);
          check_val("rs2_val", out_rs2_val, mon_e[68:37]);
          check_val("rd", 32'(out_rd), 32'(mon_e[36:32]));
          check_val("payload", out_payload, mon_e[31:0]);
        end
      end
      check_val("ren_pair", 32'(rf_ren2), 32'(rf_ren1));
      check_val("ren_accept", 32'(rf_ren1), 32'(in_valid && in_ready));
      if (rf_ren1) begin
        check_val("raddr1", 32'(rf_raddr1), 32'(in_rs1));
        check_val("raddr2", 32'(rf_raddr2), 32'(in_rs2));
      end
    end else begin
      check_val("ren_in_rst", 32'(rf_ren1 | rf_ren2), 32'd0);
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_payload = '0;
    wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0; out_ready = 1'b1;
    for (int i = 0; i < 32; i++) shadow[i] = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_rs1", out_rs1_val, 32'd0);
    check_val("rst_rs2", out_rs2_val, 32'd0);
    check_val("rst_rd", 32'(out_rd), 32'd0);
    check_val("rst_payload", out_payload, 32'd0);
    tick();

    for (int a = 1; a <= 10; a++) wb_write(5'(a), 32'h1000 + 32'(a));
    wb_write(5'd5, 32'h11);
    wb_write(5'd6, 32'h22);

    // Back-to-back at full rate, output two cycles after accept.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6; in_rd = 5'(i + 1); in_payload = 32'h100 + 32'(i);
      @(negedge clk);
      check_val("b2b_ready", 32'(in_ready), 32'd1);
      check_val("b2b_latency", 32'(out_valid), 32'(i >= 2));
      push_exp(32'h11, 32'h22, 5'(i + 1), 32'h100 + 32'(i));
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Same-edge hazard on rs1.
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'hDEAD;
    issue(5'd7, 5'd5, 5'd3, 32'h200, BYP ? 32'hDEAD : 32'h1007, 32'h11);
    wb_we = 1'b0;
    shadow[7] = 32'hDEAD;
    drain();

    // Stall: B and A hold rs2=9 while x9 is written twice.
    out_ready = 1'b0;
    issue(5'd5, 5'd9, 5'd1, 32'h300, 32'h11, BYP ? 32'hCAFE : 32'h1009);
    issue(5'd6, 5'd9, 5'd2, 32'h301, 32'h22, BYP ? 32'hCAFE : 32'h1009);
    in_valid = 1'b1; in_rs1 = 5'd9; in_rs2 = 5'd9; in_rd = 5'd3; in_payload = 32'h302;
    for (int w = 0; w < 2; w++) begin
      wb_we = 1'b1; wb_waddr = 5'd9; wb_wdata = (w == 0) ? 32'hBEEF : 32'hCAFE;
      @(negedge clk);
      check_val("stall_ready", 32'(in_ready), 32'd0);
      check_val("stall_ren", 32'(rf_ren1 | rf_ren2), 32'd0);
      check_val("stall_valid", 32'(out_valid), 32'd1);
      tick();
    end
    wb_we = 1'b0;
    shadow[9] = 32'hCAFE;
    out_ready = 1'b1;
    issue(5'd9, 5'd9, 5'd3, 32'h302, 32'hCAFE, 32'hCAFE);
    drain();

    // x0 is never forwarded, including while held in B.
    out_ready = 1'b0;
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFF_FFFF;
    issue(5'd0, 5'd0, 5'd4, 32'h400, 32'd0, 32'd0);
    repeat (3) tick();
    wb_we = 1'b0;
    out_ready = 1'b1;
    drain();

    // Random traffic with backpressure; writebacks target unread registers.
    for (int k = 0; k < 80; k++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_rs1     = 5'($urandom_range(0, 10));
      in_rs2     = 5'($urandom_range(0, 10));
      in_rd      = 5'($urandom_range(0, 31));
      in_payload = $urandom;
      out_ready  = ($urandom_range(0, 3) != 0);
      wb_we      = 1'($urandom_range(0, 1));
      wb_waddr   = 5'($urandom_range(20, 31));
      wb_wdata   = $urandom;
      @(negedge clk);
      if (in_valid && in_ready)
        push_exp(rd_shadow(in_rs1), rd_shadow(in_rs2), in_rd, in_payload);
      tick();
    end
    in_valid = 1'b0; wb_we = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with A and B both full drops both instructions.
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd5, 32'h600, 32'h1001, 32'h1002);
    issue(5'd3, 5'd4, 5'd6, 32'h601, 32'h1003, 32'h1004);
    exp_q.delete();
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd6;
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check_val("mid_rst_valid", 32'(out_valid), 32'd0);
    check_val("mid_rst_ready", 32'(in_ready), 32'd1);
    check_val("mid_rst_rs1", out_rs1_val, 32'd0);
    check_val("mid_rst_rs2", out_rs2_val, 32'd0);
    check_val("mid_rst_rd", 32'(out_rd), 32'd0);
    check_val("mid_rst_payload", out_payload, 32'd0);
    out_ready = 1'b1;
    repeat (6) tick();

    // Pipeline still works after the reset.
    issue(5'd5, 5'd6, 5'd7, 32'h700, 32'h11, 32'h22);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    check_val("watchdog", 32'd0, 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
